opl3_lfo_mod: RTL and testbench

// - Shared low-frequency modulation engine for the OPL3 core.
// - Produces the vibrato phase-increment offset and the tremolo attenuation level for each operator slot.
// - Slots are time-multiplexed through a 2-stage pipeline, so one instance serves all channels.
// - Owns both LFOs: the vibrato index counter and the tremolo triangle counter.
// - Provides a synchronous LFO clear driven by the test register.
// - Feeds the NCO phase-increment stage (vib_val) and the envelope-attenuation stage (am_val).

---
 rtl/opl3_pkg.sv | 20 ++
 rtl/opl3_lfo_counters.sv | 58 +++++
 rtl/opl3_lfo_mod.sv | 99 +++++++++
 tb/tb_opl3_lfo_mod.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/opl3_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : opl3_pkg
//  Brief     : Shared LFO constants and the LFO snapshot type for the OPL3 core.
//  Revision  : 1.0
// ============================================================================
package opl3_pkg;

  localparam int VIB_IDX_WIDTH  = 13;
  localparam int TREM_STEPS     = 210;
  localparam int TREM_DIV_WIDTH = 6;
  localparam int AM_WIDTH       = 5;

  typedef struct packed {
    logic [2:0] vib_ph;
    logic [7:0] trem_pos;
  } lfo_state_t;

endpackage
`default_nettype wire

// File: rtl/opl3_lfo_counters.sv
`default_nettype none
// ============================================================================
//  Module    : opl3_lfo_counters
//  Brief     : Vibrato index and tremolo triangle counters with synchronous clear.
//  Revision  : 1.0
// ============================================================================
module opl3_lfo_counters
  import opl3_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_sample_clk_en,
  input  logic       i_lfo_rst,
  output lfo_state_t o_state
);

  localparam logic [7:0] c_TREM_PEAK = 8'(TREM_STEPS / 2 - 1);

  logic [VIB_IDX_WIDTH-1:0]  r_vib_idx;
  logic [TREM_DIV_WIDTH-1:0] r_trem_div;
  logic [7:0]                r_trem_pos;
  logic                      r_trem_down;
  logic                      w_div_wrap;

  assign w_div_wrap = (r_trem_div == '1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vib_idx   <= '0;
      r_trem_div  <= '0;
      r_trem_pos  <= '0;
      r_trem_down <= 1'b0;
    end else if (i_lfo_rst) begin
      r_vib_idx   <= '0;
      r_trem_div  <= '0;
      r_trem_pos  <= '0;
      r_trem_down <= 1'b0;
    end else if (i_sample_clk_en) begin
      r_vib_idx  <= r_vib_idx + 1'b1;
      r_trem_div <= r_trem_div + 1'b1;
      // The turning step holds the endpoint, so each end is visited twice per period.
      if (w_div_wrap) begin
        if (!r_trem_down) begin
          if (r_trem_pos == c_TREM_PEAK) r_trem_down <= 1'b1;
          else                           r_trem_pos  <= r_trem_pos + 1'b1;
        end else begin
          if (r_trem_pos == 8'd0) r_trem_down <= 1'b0;
          else                    r_trem_pos  <= r_trem_pos - 1'b1;
        end
      end
    end
  end

  assign o_state.vib_ph   = r_vib_idx[VIB_IDX_WIDTH-1 -: 3];
  assign o_state.trem_pos = r_trem_pos;

endmodule
`default_nettype wire

// File: rtl/opl3_lfo_mod.sv
`default_nettype none
// ============================================================================
//  Module    : opl3_lfo_mod
//  Brief     : Time-multiplexed vibrato/tremolo modulation engine, 2-stage slot pipe.
//  Revision  : 1.0
// ============================================================================
module opl3_lfo_mod
  import opl3_pkg::*;
#(
  parameter int FNUM_WIDTH = 10,
  parameter int VIB_WIDTH  = 8,
  parameter int TAG_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sample_clk_en,
  input  logic                  lfo_rst,
  input  logic                  in_valid,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  input  logic [FNUM_WIDTH-1:0] fnum,
  input  logic                  dvb,
  input  logic                  dam,
  output logic                  out_valid,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic [VIB_WIDTH-1:0]  vib_val,
  output logic [AM_WIDTH-1:0]   am_val
);

  lfo_state_t w_lfo;

  opl3_lfo_counters u_counters (
    .clk             (clk),
    .reset_n         (reset_n),
    .i_sample_clk_en (sample_clk_en),
    .i_lfo_rst       (lfo_rst),
    .o_state         (w_lfo)
  );

  logic                  r_s1_valid;
  logic [TAG_WIDTH-1:0]  r_s1_tag;
  logic [FNUM_WIDTH-1:0] r_s1_fnum;
  logic                  r_s1_dvb;
  logic                  r_s1_dam;
  lfo_state_t            r_s1_lfo;

  // The snapshot is taken from the counter registers, i.e. before any update this cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_tag   <= '0;
      r_s1_fnum  <= '0;
      r_s1_dvb   <= 1'b0;
      r_s1_dam   <= 1'b0;
      r_s1_lfo   <= '0;
    end else begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_tag  <= in_tag;
        r_s1_fnum <= fnum;
        r_s1_dvb  <= dvb;
        r_s1_dam  <= dam;
        r_s1_lfo  <= w_lfo;
      end
    end
  end

  logic [2:0]           w_d0;
  logic [2:0]           w_d1;
  logic [2:0]           w_d2;
  logic [VIB_WIDTH-1:0] w_vib_mag;
  logic [VIB_WIDTH-1:0] w_vib;
  logic [AM_WIDTH-1:0]  w_am;

  assign w_d0      = 3'(r_s1_fnum >> (FNUM_WIDTH - 3));
  assign w_d1      = (r_s1_lfo.vib_ph[1:0] == 2'd3) ? (w_d0 >> 1) : w_d0;
  assign w_d2      = r_s1_dvb ? w_d1 : (w_d1 >> 1);
  assign w_vib_mag = VIB_WIDTH'(w_d2);
  assign w_vib     = r_s1_lfo.vib_ph[2] ? ~w_vib_mag : w_vib_mag;
  assign w_am      = r_s1_dam ? AM_WIDTH'(r_s1_lfo.trem_pos >> 2)
                              : AM_WIDTH'(r_s1_lfo.trem_pos >> 4);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_tag   <= '0;
      vib_val   <= '0;
      am_val    <= '0;
    end else begin
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        out_tag <= r_s1_tag;
        vib_val <= w_vib;
        am_val  <= w_am;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_opl3_lfo_mod.sv
`default_nettype none
// ============================================================================
//  Module    : tb_opl3_lfo_mod
//  Brief     : Directed vector table plus hand sequences for opl3_lfo_mod.
//  Revision  : 1.0
// ============================================================================
module tb_opl3_lfo_mod;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sample_clk_en = 1'b0;
  logic       lfo_rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [5:0] in_tag = '0;
  logic [9:0] fnum = '0;
  logic       dvb = 1'b0;
  logic       dam = 1'b0;
  logic       out_valid;
  logic [5:0] out_tag;
  logic [7:0] vib_val;
  logic [4:0] am_val;

  int n_checks = 0;
  int n_fail   = 0;

  opl3_lfo_mod dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .sample_clk_en (sample_clk_en),
    .lfo_rst       (lfo_rst),
    .in_valid      (in_valid),
    .in_tag        (in_tag),
    .fnum          (fnum),
    .dvb           (dvb),
    .dam           (dam),
    .out_valid     (out_valid),
    .out_tag       (out_tag),
    .vib_val       (vib_val),
    .am_val        (am_val)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic strobe(input int n);
    sample_clk_en = 1'b1;
    repeat (n) tick();
    sample_clk_en = 1'b0;
  endtask

  task automatic issue_check(input string name, input logic [5:0] tag, input logic [9:0] f,
                             input logic v, input logic a,
                             input logic [7:0] exp_vib, input logic [4:0] exp_am);
    in_valid = 1'b1; in_tag = tag; fnum = f; dvb = v; dam = a;
    tick();
    in_valid = 1'b0;
    chk({name, ".valid_lat1"}, 32'(out_valid), 32'd0);
    tick();
    chk({name, ".valid"}, 32'(out_valid), 32'd1);
    chk({name, ".tag"},   32'(out_tag),   32'(tag));
    chk({name, ".vib"},   32'(vib_val),   32'(exp_vib));
    chk({name, ".am"},    32'(am_val),    32'(exp_am));
  endtask

  typedef struct {
    bit         do_rst;
    int         strobes;
    logic [9:0] fnum;
    logic       dvb;
    logic       dam;
    logic [7:0] exp_vib;
    logic [4:0] exp_am;
  } vec_t;

  vec_t vecs[10];

  initial begin
    // Strobe counts are cumulative since the last reset; tremolo steps every 64 strobes.
    vecs[0] = '{1, 0,    10'h3FF, 1'b1, 1'b1, 8'h07, 5'd0};
    vecs[1] = '{0, 3072, 10'h3FF, 1'b1, 1'b1, 8'h03, 5'd12};
    vecs[2] = '{0, 1024, 10'h3FF, 1'b1, 1'b1, 8'hF8, 5'd16};
    vecs[3] = '{0, 3072, 10'h3FF, 1'b1, 1'b1, 8'hFC, 5'd24};
    vecs[4] = '{0, 1024, 10'h3FF, 1'b1, 1'b1, 8'h07, 5'd20};
    vecs[5] = '{0, 0,    10'h3FF, 1'b0, 1'b0, 8'h03, 5'd5};
    vecs[6] = '{0, 0,    10'h180, 1'b1, 1'b1, 8'h03, 5'd20};
    vecs[7] = '{1, 6720, 10'h3FF, 1'b1, 1'b1, 8'hF8, 5'd26};
    vecs[8] = '{0, 0,    10'h3FF, 1'b0, 1'b0, 8'hFC, 5'd6};
    vecs[9] = '{0, 6720, 10'h3FF, 1'b1, 1'b1, 8'hF8, 5'd0};

    reset_n = 1'b0;
    #13;
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.out_tag",   32'(out_tag),   32'd0);
    chk("reset.vib_val",   32'(vib_val),   32'd0);
    chk("reset.am_val",    32'(am_val),    32'd0);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].do_rst) do_reset();
      if (vecs[i].strobes > 0) strobe(vecs[i].strobes);
      issue_check($sformatf("vec%0d", i), 6'(i), vecs[i].fnum, vecs[i].dvb, vecs[i].dam,
                  vecs[i].exp_vib, vecs[i].exp_am);
    end

    // Latency and tagging: back-to-back, then gapped traffic.
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      logic       hv [0:40];
      logic [5:0] ht [0:40];
      logic [5:0] last_tag;
      last_tag = (pass == 0) ? 6'd0 : 6'd35;
      for (int c = 0; c < 39; c++) begin
        hv[c] = (c < 36) && ((pass == 0) || (c % 3 != 1));
        ht[c] = 6'(c);
        in_valid = hv[c];
        in_tag   = ht[c];
        fnum     = 10'h3FF;
        tick();
        if (c >= 1) begin
          if (hv[c-1]) last_tag = ht[c-1];
          chk($sformatf("lat%0d.valid[%0d]", pass, c), 32'(out_valid), 32'(hv[c-1]));
          chk($sformatf("lat%0d.tag[%0d]", pass, c),   32'(out_tag),   32'(last_tag));
        end else begin
          chk($sformatf("lat%0d.valid[0]", pass), 32'(out_valid), 32'd0);
        end
      end
      in_valid = 1'b0;
    end

    // Clear coincident with a strobe and a slot: slot sees pre-clear state.
    do_reset();
    strobe(3072);
    sample_clk_en = 1'b1; lfo_rst = 1'b1;
    in_valid = 1'b1; in_tag = 6'd1; fnum = 10'h3FF; dvb = 1'b1; dam = 1'b1;
    tick();
    sample_clk_en = 1'b0; lfo_rst = 1'b0; in_tag = 6'd2;
    tick();
    in_valid = 1'b0;
    chk("coinc.pre.tag", 32'(out_tag), 32'd1);
    chk("coinc.pre.vib", 32'(vib_val), 32'h03);
    chk("coinc.pre.am",  32'(am_val),  32'd12);
    tick();
    chk("coinc.post.tag", 32'(out_tag), 32'd2);
    chk("coinc.post.vib", 32'(vib_val), 32'h07);
    chk("coinc.post.am",  32'(am_val),  32'd0);
    strobe(3071);
    issue_check("coinc.prio", 6'd3, 10'h3FF, 1'b1, 1'b1, 8'h07, 5'd11);

    // Asynchronous reset mid-stream.
    do_reset();
    strobe(3072);
    in_valid = 1'b1; fnum = 10'h3FF; dvb = 1'b1; dam = 1'b1;
    for (int t = 5; t < 8; t++) begin
      in_tag = 6'(t);
      tick();
    end
    chk("areset.pre.valid", 32'(out_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("areset.valid", 32'(out_valid), 32'd0);
    chk("areset.tag",   32'(out_tag),   32'd0);
    chk("areset.vib",   32'(vib_val),   32'd0);
    chk("areset.am",    32'(am_val),    32'd0);
    in_valid = 1'b0;
    #2;
    reset_n = 1'b1;
    tick();
    chk("areset.drop1", 32'(out_valid), 32'd0);
    tick();
    chk("areset.drop2", 32'(out_valid), 32'd0);
    issue_check("areset.restart", 6'd9, 10'h3FF, 1'b1, 1'b1, 8'h07, 5'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
